seq_multiplier_taint: RTL and testbench

Self-contained shift-add sequential multiplier with an integrated controller and datapath. It is the parametrised successor of the split controller/datapath 1-bit taint-tracked multiplier.
- Adds a start/busy/done handshake, a signed mode, optional early termination, and separated data-taint vs timing-taint tracking.
- Sits between a requesting engine and the taint-analysis harness; product and taint are held stable until the next operation.

---
 rtl/seq_multiplier_taint_if.sv | 46 ++++
 rtl/seq_multiplier_taint.sv | 192 +++++++++++++++++++
 tb/tb_seq_multiplier_taint.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_taint_if.sv
// Request/result bundle between a requesting engine and seq_multiplier_taint.
//   master : the requesting engine (drives operands, start and taints)
//   slave  : the multiplier (drives busy/done, product and taints)
// Signals:
//   start/start_t                 request and its taint
//   signed_mode/signed_mode_t     two's-complement select and its taint
//   multiplicand/_t, multiplier/_t operands A and B with their taints
//   taint_clear                   clears sticky control taint
//   busy, done, done_t            handshake and timing taint
//   product, product_t            2*WIDTH result and its data taint
//   iter_count                    iterations used by the last operation
interface seq_multiplier_taint_if #(
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic               start;
   logic               start_t;
   logic               signed_mode;
   logic               signed_mode_t;
   logic [WIDTH-1:0]   multiplicand;
   logic               multiplicand_t;
   logic [WIDTH-1:0]   multiplier;
   logic               multiplier_t;
   logic               taint_clear;
   logic               busy;
   logic               done;
   logic               done_t;
   logic [2*WIDTH-1:0] product;
   logic               product_t;
   logic [CNT_W-1:0]   iter_count;

   modport master (
      output start, start_t, signed_mode, signed_mode_t,
             multiplicand, multiplicand_t, multiplier, multiplier_t,
             taint_clear,
      input  busy, done, done_t, product, product_t, iter_count
   );

   modport slave (
      input  start, start_t, signed_mode, signed_mode_t,
             multiplicand, multiplicand_t, multiplier, multiplier_t,
             taint_clear,
      output busy, done, done_t, product, product_t, iter_count
   );
endinterface

// File: rtl/seq_multiplier_taint.sv
// Shift-add sequential multiplier with start/busy/done handshake, optional
// two's-complement mode, optional early termination, and separate tracking of
// data taint (product_t) and timing taint (done_t).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  seq_multiplier_taint_if slave modport (operands, handshake, result)
// Parameters:
//   WIDTH      operand width (>=2), product is 2*WIDTH bits
//   SIGNED_EN  1 allows signed_mode, 0 forces unsigned and ignores it
//   EARLY_EXIT 1 stops iterating once the remaining multiplier bits are zero
module seq_multiplier_taint #(
   parameter int unsigned WIDTH      = 32,
   parameter bit          SIGNED_EN  = 1'b1,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input logic                    clk,
   input logic                    rst,
   seq_multiplier_taint_if.slave  bus
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state;
   logic [PW-1:0]      acc;
   logic [WIDTH-1:0]   mcand;
   logic [CNT_W-1:0]   remaining;
   logic               neg;
   logic               op_t;
   logic               ctrl_sticky;

   logic               busy_q;
   logic               done_q;
   logic               done_t_q;
   logic [PW-1:0]      product_q;
   logic               product_t_q;
   logic [CNT_W-1:0]   iter_q;

   // Combinational helpers
   logic               signed_act;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic               load;
   logic               load_t;
   logic [WIDTH:0]     sum;
   logic [PW-1:0]      acc_step;
   logic [CNT_W-1:0]   rem_dec;
   logic [WIDTH-1:0]   live_mask;
   logic               bits_left_zero;
   logic               run_last;
   logic [PW-1:0]      aligned;
   logic [PW-1:0]      fix_val;
   logic               sticky_next;

   // Operand conditioning: magnitudes and result sign for signed mode.
   // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
   always_comb begin
      signed_act = 1'b0;
      a_neg      = 1'b0;
      b_neg      = 1'b0;
      a_abs      = bus.multiplicand;
      b_abs      = bus.multiplier;
      load       = 1'b0;
      load_t     = 1'b0;

      signed_act = SIGNED_EN && bus.signed_mode;
      a_neg      = signed_act && bus.multiplicand[WIDTH-1];
      b_neg      = signed_act && bus.multiplier[WIDTH-1];
      if (a_neg) a_abs = (~bus.multiplicand) + WIDTH'(1);
      if (b_neg) b_abs = (~bus.multiplier) + WIDTH'(1);

      load   = (state == S_IDLE) && bus.start;
      load_t = bus.multiplicand_t | bus.multiplier_t | bus.start_t |
               (SIGNED_EN && bus.signed_mode_t);
   end

   // One shift-add step plus the termination decision for RUN.
   always_comb begin
      sum            = '0;
      acc_step       = '0;
      rem_dec        = '0;
      live_mask      = '0;
      bits_left_zero = 1'b0;
      run_last       = 1'b0;

      sum = {1'b0, acc[PW-1:WIDTH]} + {1'b0, mcand};
      if (acc[0]) acc_step = {sum, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[PW-1:1]};

      rem_dec = remaining - CNT_W'(1);
      // Low rem_dec bits of the shifted accumulator are still multiplier bits.
      live_mask      = ~({WIDTH{1'b1}} << rem_dec);
      bits_left_zero = (acc_step[WIDTH-1:0] & live_mask) == '0;
      run_last       = (rem_dec == '0) || (EARLY_EXIT && bits_left_zero);
   end

   // Result alignment after early exit and sign restoration.
   always_comb begin
      aligned = '0;
      fix_val = '0;
      aligned = acc >> remaining;
      fix_val = neg ? ((~aligned) + PW'(1)) : aligned;
   end

   // Sticky control taint; a new taint in the same cycle beats taint_clear.
   always_comb begin
      sticky_next = 1'b0;
      sticky_next = (bus.taint_clear ? 1'b0 : ctrl_sticky) |
                    bus.start_t |
                    (SIGNED_EN && bus.signed_mode_t) |
                    (EARLY_EXIT && load && bus.multiplier_t);
   end

   // Controller and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         acc         <= '0;
         mcand       <= '0;
         remaining   <= '0;
         neg         <= 1'b0;
         op_t        <= 1'b0;
         ctrl_sticky <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_t_q    <= 1'b0;
         product_q   <= '0;
         product_t_q <= 1'b0;
         iter_q      <= '0;
      end else begin
         ctrl_sticky <= sticky_next;
         done_t_q    <= sticky_next;
         done_q      <= 1'b0;

         case (state)
            S_IDLE: begin
               if (load) begin
                  acc       <= {{WIDTH{1'b0}}, b_abs};
                  mcand     <= a_abs;
                  remaining <= CNT_W'(WIDTH);
                  neg       <= a_neg ^ b_neg;
                  op_t      <= load_t;
                  iter_q    <= '0;
                  busy_q    <= 1'b1;
                  state     <= S_RUN;
               end
            end

            S_RUN: begin
               acc       <= acc_step;
               remaining <= rem_dec;
               iter_q    <= iter_q + CNT_W'(1);
               if (run_last) state <= S_FIX;
            end

            S_FIX: begin
               product_q   <= fix_val;
               product_t_q <= op_t | ctrl_sticky;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
               state       <= S_DONE;
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.done_t     = done_t_q;
   assign bus.product    = product_q;
   assign bus.product_t  = product_t_q;
   assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_seq_multiplier_taint.sv
// Directed bench for seq_multiplier_taint. Two 8-bit instances share one
// stimulus stream: u_dut0 without early exit, u_dut1 with early exit.
module tb_seq_multiplier_taint;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start_t = 1'b0;
   logic       sm = 1'b0;
   logic       sm_t = 1'b0;
   logic [7:0] a = '0;
   logic       a_t = 1'b0;
   logic [7:0] b = '0;
   logic       b_t = 1'b0;
   logic       tclr = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int l0, l1, c0, c1;

   always #5 clk = ~clk;

   seq_multiplier_taint_if #(.WIDTH(8)) if0 ();
   seq_multiplier_taint_if #(.WIDTH(8)) if1 ();

   assign if0.start          = start;
   assign if0.start_t        = start_t;
   assign if0.signed_mode    = sm;
   assign if0.signed_mode_t  = sm_t;
   assign if0.multiplicand   = a;
   assign if0.multiplicand_t = a_t;
   assign if0.multiplier     = b;
   assign if0.multiplier_t   = b_t;
   assign if0.taint_clear    = tclr;

   assign if1.start          = start;
   assign if1.start_t        = start_t;
   assign if1.signed_mode    = sm;
   assign if1.signed_mode_t  = sm_t;
   assign if1.multiplicand   = a;
   assign if1.multiplicand_t = a_t;
   assign if1.multiplier     = b;
   assign if1.multiplier_t   = b_t;
   assign if1.taint_clear    = tclr;

   seq_multiplier_taint #(.WIDTH(8), .SIGNED_EN(1'b1), .EARLY_EXIT(1'b0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   seq_multiplier_taint #(.WIDTH(8), .SIGNED_EN(1'b1), .EARLY_EXIT(1'b1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one request for a single cycle; returns at the negedge after the start edge.
   task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic smv,
                           input logic a_tv, input logic b_tv);
      @(negedge clk);
      a = av; b = bv; sm = smv; a_t = a_tv; b_t = b_tv; start = 1'b1;
      @(negedge clk);
      start = 1'b0; start_t = 1'b0; a_t = 1'b0; b_t = 1'b0; sm_t = 1'b0;
   endtask

   // Fixed window: first done edge index after the start edge and done-high cycle counts.
   task automatic wait_done(output int lat0, output int lat1, output int cnt0, output int cnt1);
      lat0 = -1; lat1 = -1; cnt0 = 0; cnt1 = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (if0.done) begin cnt0++; if (lat0 < 0) lat0 = k; end
         if (if1.done) begin cnt1++; if (lat1 < 0) lat1 = k; end
      end
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      tclr = 1'b1;
      @(negedge clk);
      tclr = 1'b0;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_busy0",    64'(if0.busy),       64'd0);
      check("rst_done1",    64'(if1.done),       64'd0);
      check("rst_product0", 64'(if0.product),    64'd0);
      check("rst_iter1",    64'(if1.iter_count), 64'd0);
      check("rst_done_t1",  64'(if1.done_t),     64'd0);
      rst = 1'b0;

      // Unsigned 13*11, clean
      start_op(8'd13, 8'd11, 1'b0, 1'b0, 1'b0);
      check("u13x11_busy0", 64'(if0.busy), 64'd1);
      wait_done(l0, l1, c0, c1);
      check("u13x11_lat0",   64'(l0), 64'd9);
      check("u13x11_lat1",   64'(l1), 64'd5);
      check("u13x11_pulse0", 64'(c0), 64'd1);
      check("u13x11_pulse1", 64'(c1), 64'd1);
      check("u13x11_prod0",  64'(if0.product), 64'h008F);
      check("u13x11_prod1",  64'(if1.product), 64'h008F);
      check("u13x11_iter0",  64'(if0.iter_count), 64'd8);
      check("u13x11_iter1",  64'(if1.iter_count), 64'd4);
      check("u13x11_pt0",    64'(if0.product_t), 64'd0);
      check("u13x11_dt0",    64'(if0.done_t), 64'd0);
      check("u13x11_busyend",64'(if0.busy), 64'd0);

      // Signed -3*5
      start_op(8'hFD, 8'h05, 1'b1, 1'b0, 1'b0);
      wait_done(l0, l1, c0, c1);
      check("s_m3x5_prod0", 64'(if0.product), 64'hFFF1);
      check("s_m3x5_prod1", 64'(if1.product), 64'hFFF1);
      check("s_m3x5_iter1", 64'(if1.iter_count), 64'd3);
      check("s_m3x5_lat1",  64'(l1), 64'd4);

      // Signed -128*-128
      start_op(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
      wait_done(l0, l1, c0, c1);
      check("s_min_prod0", 64'(if0.product), 64'h4000);
      check("s_min_prod1", 64'(if1.product), 64'h4000);
      check("s_min_iter1", 64'(if1.iter_count), 64'd8);

      // Early exit: B=1 and B=0
      start_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      wait_done(l0, l1, c0, c1);
      check("ee_b1_lat1",  64'(l1), 64'd2);
      check("ee_b1_iter1", 64'(if1.iter_count), 64'd1);
      check("ee_b1_prod1", 64'(if1.product), 64'h00FF);
      check("ee_b1_prod0", 64'(if0.product), 64'h00FF);
      check("ee_b1_iter0", 64'(if0.iter_count), 64'd8);

      start_op(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
      wait_done(l0, l1, c0, c1);
      check("ee_b0_iter1", 64'(if1.iter_count), 64'd1);
      check("ee_b0_prod1", 64'(if1.product), 64'h0000);
      check("ee_b0_prod0", 64'(if0.product), 64'h0000);

      // Multiplier taint: data taint on both, timing taint only with early exit
      start_op(8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
      wait_done(l0, l1, c0, c1);
      check("bt_prod1", 64'(if1.product),   64'h000F);
      check("bt_pt0",   64'(if0.product_t), 64'd1);
      check("bt_pt1",   64'(if1.product_t), 64'd1);
      check("bt_dt0",   64'(if0.done_t),    64'd0);
      check("bt_dt1",   64'(if1.done_t),    64'd1);
      pulse_clear();
      check("clr_dt1",  64'(if1.done_t),    64'd0);
      check("clr_pt1",  64'(if1.product_t), 64'd1);
      start_op(8'd2, 8'd3, 1'b0, 1'b0, 1'b0);
      wait_done(l0, l1, c0, c1);
      check("clean_prod1", 64'(if1.product),   64'h0006);
      check("clean_pt1",   64'(if1.product_t), 64'd0);
      check("clean_pt0",   64'(if0.product_t), 64'd0);

      // Tainted second start while busy is ignored
      start_op(8'h0C, 8'h81, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("ign_busy1", 64'(if1.busy),    64'd1);
      check("ign_hold0", 64'(if0.product), 64'h0006);
      a = 8'hFF; b = 8'hFF; start = 1'b1; start_t = 1'b1;
      @(negedge clk);
      start = 1'b0; start_t = 1'b0;
      wait_done(l0, l1, c0, c1);
      check("ign_pulse1", 64'(c1), 64'd1);
      check("ign_prod0",  64'(if0.product), 64'h060C);
      check("ign_prod1",  64'(if1.product), 64'h060C);
      check("ign_iter1",  64'(if1.iter_count), 64'd8);
      check("ign_dt0",    64'(if0.done_t), 64'd1);
      check("ign_dt1",    64'(if1.done_t), 64'd1);
      check("ign_pt1",    64'(if1.product_t), 64'd1);
      pulse_clear();

      // Reset during iteration 4
      start_op(8'h55, 8'hAA, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mrst_busy0", 64'(if0.busy),       64'd0);
      check("mrst_prod0", 64'(if0.product),    64'd0);
      check("mrst_pt0",   64'(if0.product_t),  64'd0);
      check("mrst_iter1", 64'(if1.iter_count), 64'd0);
      @(negedge clk);
      @(negedge clk);
      check("mrst_done0", 64'(if0.done), 64'd0);
      check("mrst_done1", 64'(if1.done), 64'd0);
      rst = 1'b0;
      start_op(8'h55, 8'hAA, 1'b0, 1'b0, 1'b0);
      wait_done(l0, l1, c0, c1);
      check("post_lat0",  64'(l0), 64'd9);
      check("post_prod0", 64'(if0.product), 64'h3872);
      check("post_prod1", 64'(if1.product), 64'h3872);
      check("post_iter1", 64'(if1.iter_count), 64'd8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
